// File: rtl/obstacle_scheduler.sv
// Obstacle slot scheduler for a side-scrolling runner: moves three obstacle slots
// each frame, spawns new ones on an LFSR-randomised gap and ramps scroll speed.
module obstacle_scheduler #(
  parameter int          SPAWN_X     = 680,
  parameter int          DX_INIT     = 5,
  parameter int          DX_MAX      = 12,
  parameter int          RAMP_FRAMES = 600,
  parameter int          MIN_GAP     = 40,
  parameter int          BIRD_MIN_DX = 7,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  game_state,
  input  logic        frame_tick,
  output logic [2:0]  obs_valid,
  output logic [10:0] obs_x0,
  output logic [10:0] obs_x1,
  output logic [10:0] obs_x2,
  output logic [1:0]  obs_type0,
  output logic [1:0]  obs_type1,
  output logic [1:0]  obs_type2,
  output logic [3:0]  cur_dx,
  output logic        spawn_pulse
);
  localparam logic [10:0] SPAWN_X_L   = 11'(SPAWN_X);
  localparam logic [3:0]  DX_INIT_L   = 4'(DX_INIT);
  localparam logic [3:0]  DX_MAX_L    = 4'(DX_MAX);
  localparam logic [3:0]  BIRD_DX_L   = 4'(BIRD_MIN_DX);
  localparam logic [15:0] GAP_INIT_L  = 16'(MIN_GAP);
  localparam logic [15:0] RAMP_LAST_L = 16'(RAMP_FRAMES - 1);

  logic [15:0]      lfsr_q, lfsr_d;
  logic [2:0]       valid_q, valid_d;
  logic [2:0][10:0] x_q, x_d;
  logic [2:0][1:0]  type_q, type_d;
  logic [3:0]       dx_q, dx_d;
  logic [15:0]      gap_q, gap_d;
  logic [15:0]      fcnt_q, fcnt_d;
  logic             pulse_q, pulse_d;
  logic [1:0]       spawn_idx;
  logic             spawn_ok;

  // Birds only appear once the game is fast enough to make them jumpable.
  function automatic logic [1:0] spawn_type(input logic [1:0] r, input logic [3:0] dx);
    if (r == 2'b11) return 2'b01;
    if ((r == 2'b10) && (dx < BIRD_DX_L)) return 2'b01;
    return r;
  endfunction

  always_comb begin
    lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    valid_d   = valid_q;
    x_d       = x_q;
    type_d    = type_q;
    dx_d      = dx_q;
    gap_d     = gap_q;
    fcnt_d    = fcnt_q;
    pulse_d   = 1'b0;
    spawn_idx = 2'd0;
    spawn_ok  = 1'b0;
    case (game_state)
      2'b00: begin
        valid_d = '0;
        x_d     = {3{SPAWN_X_L}};
        type_d  = '0;
        dx_d    = DX_INIT_L;
        gap_d   = GAP_INIT_L;
        fcnt_d  = '0;
      end
      2'b01: begin
        if (frame_tick) begin
          for (int i = 0; i < 3; i++) begin
            if (valid_q[i]) begin
              if (x_q[i] <= {7'd0, dx_q}) valid_d[i] = 1'b0;
              else                        x_d[i]     = x_q[i] - {7'd0, dx_q};
            end
          end
          // Descending scan so the lowest free index (after retirement) wins.
          for (int i = 2; i >= 0; i--) begin
            if (!valid_d[i]) begin
              spawn_ok  = 1'b1;
              spawn_idx = 2'(i);
            end
          end
          if (gap_q != '0) begin
            gap_d = gap_q - 16'd1;
          end else if (spawn_ok) begin
            valid_d[spawn_idx] = 1'b1;
            x_d[spawn_idx]     = SPAWN_X_L;
            type_d[spawn_idx]  = spawn_type(lfsr_q[1:0], dx_q);
            gap_d              = GAP_INIT_L + {10'd0, lfsr_q[7:2]};
            pulse_d            = 1'b1;
          end
          if (fcnt_q == RAMP_LAST_L) begin
            fcnt_d = '0;
            if (dx_q < DX_MAX_L) dx_d = dx_q + 4'd1;
          end else begin
            fcnt_d = fcnt_q + 16'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q  <= LFSR_SEED;
      valid_q <= '0;
      x_q     <= {3{SPAWN_X_L}};
      type_q  <= '0;
      dx_q    <= DX_INIT_L;
      gap_q   <= GAP_INIT_L;
      fcnt_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      valid_q <= valid_d;
      x_q     <= x_d;
      type_q  <= type_d;
      dx_q    <= dx_d;
      gap_q   <= gap_d;
      fcnt_q  <= fcnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign obs_valid   = valid_q;
  assign obs_x0      = x_q[0];
  assign obs_x1      = x_q[1];
  assign obs_x2      = x_q[2];
  assign obs_type0   = type_q[0];
  assign obs_type1   = type_q[1];
  assign obs_type2   = type_q[2];
  assign cur_dx      = dx_q;
  assign spawn_pulse = pulse_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Bench for obstacle_scheduler: an abstract per-frame game model predicts every
// output each clock; a few hand-derived values pin the model itself.
module tb_obstacle_scheduler;
  logic        clk;
  logic        rst;
  logic [1:0]  game_state;
  logic        frame_tick;
  logic [2:0]  obs_valid;
  logic [10:0] obs_x0, obs_x1, obs_x2;
  logic [1:0]  obs_type0, obs_type1, obs_type2;
  logic [3:0]  cur_dx;
  logic        spawn_pulse;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int mv[3];
  int mx[3];
  int mt[3];
  int mdx, mgap, mfcnt, mpulse;
  int defer_cnt = 0;
  logic [15:0] mlfsr;

  obstacle_scheduler dut (
    .clk(clk), .rst(rst), .game_state(game_state), .frame_tick(frame_tick),
    .obs_valid(obs_valid), .obs_x0(obs_x0), .obs_x1(obs_x1), .obs_x2(obs_x2),
    .obs_type0(obs_type0), .obs_type1(obs_type1), .obs_type2(obs_type2),
    .cur_dx(cur_dx), .spawn_pulse(spawn_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [15:0] act, input int exp);
    checks++;
    if (act !== 16'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_idle();
    for (int i = 0; i < 3; i++) begin
      mv[i] = 0;
      mx[i] = 680;
      mt[i] = 0;
    end
    mdx    = 5;
    mgap   = 40;
    mfcnt  = 0;
    mpulse = 0;
  endtask

  // One clock of the game as described: retire/move, then spawn decision, then ramp.
  task automatic model_step(input logic r, input logic [1:0] g, input logic f);
    logic [15:0] old;
    int free;
    int t;
    old = mlfsr;
    if (r) begin
      model_idle();
      mlfsr = 16'hACE1;
      return;
    end
    mlfsr  = {old[14:0], old[15] ^ old[13] ^ old[12] ^ old[10]};
    mpulse = 0;
    if (g == 2'b00) begin
      model_idle();
    end else if (g == 2'b01 && f) begin
      for (int i = 0; i < 3; i++) begin
        if (mv[i] != 0) begin
          if (mx[i] <= mdx) mv[i] = 0;
          else              mx[i] = mx[i] - mdx;
        end
      end
      if (mgap > 0) begin
        mgap = mgap - 1;
      end else begin
        free = -1;
        for (int i = 0; i < 3; i++) begin
          if (mv[i] == 0) begin
            free = i;
            break;
          end
        end
        if (free < 0) begin
          defer_cnt++;
        end else begin
          t = int'(old[1:0]);
          if (t == 3 || (t == 2 && mdx < 7)) t = 1;
          mv[free] = 1;
          mx[free] = 680;
          mt[free] = t;
          mpulse   = 1;
          mgap     = 40 + int'(old[7:2]);
        end
      end
      mfcnt = mfcnt + 1;
      if (mfcnt == 600) begin
        mfcnt = 0;
        if (mdx < 12) mdx = mdx + 1;
      end
    end
  endtask

  task automatic compare_all();
    chk("obs_valid", 16'(obs_valid), mv[0] + 2 * mv[1] + 4 * mv[2]);
    chk("obs_x0", 16'(obs_x0), mx[0]);
    chk("obs_x1", 16'(obs_x1), mx[1]);
    chk("obs_x2", 16'(obs_x2), mx[2]);
    chk("obs_type0", 16'(obs_type0), mt[0]);
    chk("obs_type1", 16'(obs_type1), mt[1]);
    chk("obs_type2", 16'(obs_type2), mt[2]);
    chk("cur_dx", 16'(cur_dx), mdx);
    chk("spawn_pulse", 16'(spawn_pulse), mpulse);
  endtask

  // Drive inputs for one clock, advance the model, then compare on the falling edge.
  task automatic step(input logic r, input logic [1:0] g, input logic f);
    rst        = r;
    game_state = g;
    frame_tick = f;
    model_step(r, g, f);
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  task automatic run_gap(input int max_idle);
    int n;
    n = $urandom_range(max_idle, 0);
    repeat (n) step(1'b0, 2'b01, 1'b0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid"}, 16'(obs_valid), 0);
    chk({tag, "_x0"}, 16'(obs_x0), 680);
    chk({tag, "_x1"}, 16'(obs_x1), 680);
    chk({tag, "_x2"}, 16'(obs_x2), 680);
    chk({tag, "_types"}, 16'({obs_type2, obs_type1, obs_type0}), 0);
    chk({tag, "_dx"}, 16'(cur_dx), 5);
    chk({tag, "_pulse"}, 16'(spawn_pulse), 0);
  endtask

  initial begin
    logic [1:0] g;
    rst        = 1'b1;
    game_state = 2'b00;
    frame_tick = 1'b0;
    mlfsr      = 16'hACE1;
    model_idle();

    step(1'b1, 2'b01, 1'b1);
    step(1'b1, 2'b01, 1'b1);
    check_idle("reset");
    repeat (3) step(1'b0, 2'b00, 1'b0);

    // Long run from idle: first spawn, first move, retirement at x==dx, speed ramp.
    for (int i = 1; i <= 4400; i++) begin
      step(1'b0, 2'b01, 1'b1);
      if (i <= 42) chk("first_spawn_pulse", 16'(spawn_pulse), (i == 41) ? 1 : 0);
      if (i == 41) begin
        chk("first_spawn_valid", 16'(obs_valid), 1);
        chk("first_spawn_x0", 16'(obs_x0), 680);
      end
      if (i == 42) chk("first_move_x0", 16'(obs_x0), 675);
      if (i == 176) begin
        chk("slot0_at_dx_x0", 16'(obs_x0), 5);
        chk("slot0_at_dx_valid", 16'(obs_valid[0]), 1);
      end
      if (i == 177) begin
        chk("slot0_retire_valid", 16'(obs_valid[0]), mpulse);
        chk("slot0_retire_x0", 16'(obs_x0), (mpulse != 0) ? 680 : 5);
      end
      if (i == 599)  chk("dx_before_ramp", 16'(cur_dx), 5);
      if (i == 600)  chk("dx_after_ramp", 16'(cur_dx), 6);
      if (i == 4200) chk("dx_saturated", 16'(cur_dx), 12);
      if (i == 4400) chk("dx_stays_max", 16'(cur_dx), 12);
      run_gap(2);
    end

    // Dead freezes everything, including with ticks and with state 11.
    for (int k = 0; k < 10; k++) begin
      step(1'b0, (k < 5) ? 2'b10 : 2'b11, 1'b1);
      chk("dead_pulse", 16'(spawn_pulse), 0);
      chk("dead_dx", 16'(cur_dx), 12);
    end
    repeat (4) step(1'b0, 2'b10, 1'b0);

    for (int k = 0; k < 30; k++) begin
      step(1'b0, 2'b01, 1'b1);
      run_gap(1);
    end

    step(1'b0, 2'b10, 1'b1);
    step(1'b0, 2'b00, 1'b0);
    check_idle("dead_to_idle");

    // Dense ticks at low speed so slots fill up and spawns get deferred.
    for (int k = 0; k < 700; k++) begin
      step(1'b0, 2'b01, 1'b1);
      if ($urandom_range(7, 0) == 0) step(1'b0, 2'b01, 1'b0);
    end

    step(1'b1, 2'b01, 1'b1);
    chk("mid_rst_pulse", 16'(spawn_pulse), 0);
    chk("mid_rst_valid", 16'(obs_valid), 0);
    chk("mid_rst_dx", 16'(cur_dx), 5);
    step(1'b0, 2'b00, 1'b0);

    // Random state changes, ticks and occasional resets.
    g = 2'b01;
    for (int k = 0; k < 5000; k++) begin
      if ($urandom_range(99, 0) == 0) begin
        case ($urandom_range(9, 0))
          0, 1:    g = 2'b00;
          2, 3, 4: g = 2'(2 + $urandom_range(1, 0));
          default: g = 2'b01;
        endcase
      end
      step(($urandom_range(499, 0) == 0) ? 1'b1 : 1'b0, g,
           ($urandom_range(2, 0) == 0) ? 1'b1 : 1'b0);
    end

    $display("Model deferred spawns: %0d", defer_cnt);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/obstacle_scheduler.md
OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

Interface
REQ-001 Parameter SPAWN_X, default 680: x coordinate loaded into a slot on spawn.
REQ-002 Parameter DX_INIT, default 5: pixels per frame after idle or reset.
REQ-003 Parameter DX_MAX, default 12: speed saturation value.
REQ-004 Parameter RAMP_FRAMES, default 600: run-state frames per speed increment.
REQ-005 Parameter MIN_GAP, default 40: minimum frame ticks between spawns.
REQ-006 Parameter BIRD_MIN_DX, default 7: lowest speed at which the bird type may spawn.
REQ-007 Parameter LFSR_SEED, default 16'hACE1: non-zero LFSR reset value.
REQ-008 clk  input  1  system clock; single clock domain; all state on rising edge.
REQ-009 rst  input  1  synchronous, active-high reset.
REQ-010 game_state  input  2  00 idle, 01 run, 10 dead, 11 treated as dead.
REQ-011 frame_tick  input  1  one-clk pulse per video frame, already in clk domain.
REQ-012 obs_valid  output  3  per-slot occupancy, bit i = slot i.
REQ-013 obs_x0, obs_x1, obs_x2  output  11 each  slot x positions.
REQ-014 obs_type0, obs_type1, obs_type2  output  2 each  00 small cactus, 01 large cactus, 10 bird.
REQ-015 cur_dx  output  4  current scroll speed, shared with the background scroller.
REQ-016 spawn_pulse  output  1  high for exactly one clk when a spawn is committed.

Function
REQ-017 All outputs SHALL be registered and SHALL update on the clk edge that samples frame_tick high (one-clk latency).
REQ-018 A 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every clk in every state except reset.
REQ-019 Idle SHALL hold obs_valid=000, all obs_x=SPAWN_X, all types=00, cur_dx=DX_INIT, gap_cnt=MIN_GAP, frame_cnt=0, spawn_pulse=0.
REQ-020 Run with frame_tick=0 SHALL hold all state except the LFSR.
REQ-021 Run frame_tick, movement: each valid slot with x <= cur_dx SHALL be invalidated (retired), x left unchanged; otherwise x SHALL become x - cur_dx; invalid slots are untouched.
REQ-022 Run frame_tick, spawn: if gap_cnt==0 and at least one slot is free after retirement, the lowest-index free slot SHALL become valid with x=SPAWN_X, spawn_pulse=1, and gap_cnt reloaded to MIN_GAP + LFSR[7:2].
REQ-023 Run frame_tick, gap_cnt!=0: gap_cnt SHALL decrement by 1 and no spawn SHALL occur.
REQ-024 Run frame_tick, gap_cnt==0 and no slot free: gap_cnt SHALL hold at 0 and the spawn SHALL be deferred to the first tick that frees a slot.
REQ-025 A slot retired on a tick SHALL be eligible for a spawn on the same tick.
REQ-026 Spawn type SHALL be LFSR[1:0], with 11 mapped to 01; 10 SHALL be mapped to 01 when cur_dx < BIRD_MIN_DX.
REQ-027 Speed ramp: frame_cnt SHALL increment on each run-state tick; at RAMP_FRAMES-1 it SHALL wrap to 0 and cur_dx SHALL increment, saturating at DX_MAX.
REQ-028 Speed, movement and spawn SHALL all use the cur_dx value from before the tick.
REQ-029 Dead (10 or 11) SHALL freeze all outputs and counters regardless of frame_tick; spawn_pulse SHALL be 0.
REQ-030 Any transition into idle, from run or from dead, SHALL apply the idle values of REQ-019 on the next clk.
REQ-031 A dead-to-run transition SHALL resume from the frozen state without clearing it.

Reset
REQ-032 When rst=1 on a clk edge, all registers SHALL take their idle values and the LFSR SHALL take LFSR_SEED; rst SHALL take priority over game_state and frame_tick.
REQ-033 Reset asserted mid-run SHALL discard all slots, and no spawn_pulse SHALL be emitted on that edge.

Verification
REQ-034 rst for 2 clks -> obs_valid=000, cur_dx=5, obs_x0..2=680, spawn_pulse=0.
REQ-035 Idle->run, then 41 frame_ticks -> spawn_pulse on tick 41 only, obs_valid=001, obs_x0=680; tick 42 -> obs_x0=675.
REQ-036 Slot 0 at x=5 with cur_dx=5, one tick -> obs_valid[0]=0, obs_x0 stays 5.
REQ-037 600 run ticks -> cur_dx=6; 4200 ticks -> cur_dx=12, and it stays 12 afterward.
REQ-038 All three slots valid and gap_cnt=0 -> no spawn and gap_cnt holds 0; on the tick slot 1 retires -> slot 1 respawns at 680 with spawn_pulse=1.
REQ-039 Run->dead with 10 ticks -> outputs unchanged; dead->idle -> idle values of REQ-019 on the next clk.
